// File: rtl/lc4_divider_seq.sv
// rtl/lc4_divider_seq.sv - multi-cycle unsigned restoring divider for the LC4 ALU (DIV/MOD)
module lc4_divider_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  div_q;
    logic [CW-1:0] count;

    logic [W:0]    trial;
    logic [W-1:0]  diff;
    logic          take;

    // The trial value needs W+1 bits, but after a restoring step the partial
    // remainder is always below the divisor, so W stored bits suffice.
    always_comb begin
        trial = {rem_q, quo_q[W-1]};
        take  = (trial >= {1'b0, div_q});
        diff  = trial[W-1:0] - div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CW'(W - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_q <= divisor;
                        rem_q <= '0;
                        count <= '0;
                        // Divide-by-zero yields 0/0 without running the loop.
                        quo_q <= (divisor == '0) ? '0 : dividend;
                    end
                end
                RUN: begin
                    rem_q <= take ? diff : trial[W-1:0];
                    quo_q <= {quo_q[W-2:0], take};
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = ~in_ready;

endmodule
